pwm_capture: RTL and testbench
==============================

# pwm_capture

Measures the high time and period of an incoming pulse-width-modulated signal, in prescaled clock ticks, and reports each completed cycle with a one-cycle strobe. It is the decode end of the LED brightness path: the triangle/sawtooth level generator feeds a PWM encoder, and this block recovers the duty information from a PWM pin, either looped back for self-test or from an external source. Stuck-high and stuck-low inputs are reported as 100 % and 0 % via a timeout.

## Interface
- `WIDTH`, default 8: width of tick counter and of measurement outputs; `MAX` = 2^WIDTH − 1.
- `PRESCALER`, default 0: one tick every 2^PRESCALER `clk` cycles.
- `SYNC_STAGES`, default 2: number of input synchronizer flops, minimum 2.

Ports:
- `clk`, input, 1: single clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `pwm_in`, input, 1: asynchronous PWM input.
- `high_time`, output, WIDTH: ticks the input was high in the last measured cycle.
- `period`, output, WIDTH: ticks from rising edge to rising edge in the last measured cycle.
- `valid`, output, 1: one-`clk` strobe when `high_time` and `period` update.
- `timeout`, output, 1: level; set when a measurement ends by saturation, cleared by the next normal measurement.

## Operation
- **Synchronizer:** `pwm_in` passes through `SYNC_STAGES` flops, then one delay flop.
  - `rise` = synced & ~delayed; `fall` = ~synced & delayed.
  - All of these flops reset to 0.
- **Prescaler:** free-running PRESCALER-bit counter, reset 0.
  - `tick` = counter all-ones; for PRESCALER = 0, `tick` = 1 every cycle.
  - The prescaler is never restarted by edges.
- **Tick counter `cnt`:**
  - On a cycle where the state is left because of an edge: `cnt` ← (tick ? 1 : 0).
  - Otherwise on a tick: `cnt` ← `cnt` + 1.
  - Otherwise: `cnt` holds.
- **State machine:**
  - IDLE: wait for synced input = 0, then go to ARM. This discards any pulse already in progress at reset or after a timeout.
  - ARM: on `rise`, go to HIGH and restart `cnt`.
  - HIGH: on `fall`, latch `hi_cnt` ← `cnt`, go to LOW and restart `cnt`.
  - LOW: on `rise`, set `high_time` ← `hi_cnt`, `period` ← `hi_cnt` + `cnt` (saturating at MAX), `valid` ← 1, `timeout` ← 0. Go to HIGH and restart `cnt`.
- **Period saturation:** if `hi_cnt` + `cnt` > MAX, `period` = MAX and `timeout` ← 1 for that measurement.
- **Timeout (any state):** when `tick` occurs, `cnt` = MAX and no edge occurs in the same cycle:
  - `high_time` ← (synced input ? MAX : 0);
  - `period` ← MAX;
  - `valid` ← 1 and `timeout` ← 1;
  - `cnt` ← 0, state → IDLE.
- **Edge priority:** an edge in the same cycle as a would-be timeout takes priority; the edge is processed normally.
- **Reset values:** `high_time` = 0, `period` = 0, `valid` = 0, `timeout` = 0, state = IDLE, `cnt` = 0, `hi_cnt` = 0.
- **Reset mid-measurement:** the measurement is abandoned with no `valid`. The first report after reset needs a full low→high→low→high sequence.

## Timing
- **Latency:** let `k` be the first `clk` edge that samples `pwm_in` = 1. `valid` is high during the cycle after edge `k` + `SYNC_STAGES`. Both edges see the same synchronizer delay, so the delay cancels in the measurements.
- **Accuracy (PRESCALER = 0):** high phase of H cycles and low phase of L cycles gives `high_time` = H and `period` = H + L exactly. With a prescaler, each value is within ±1 tick.
- **Minimum phase:** 1 `clk`. Phases shorter than one `clk` may be lost.
- **`valid` spacing:** at most one `valid` per input period. `valid` is never high on two consecutive cycles.
- **Output stability:** `high_time` and `period` hold between `valid` strobes.

## Structure
- **Shared package (e.g. `led_pkg`):**
  - `pwm_cap_state_t` enum {IDLE, ARM, HIGH, LOW};
  - a `cnt_max(width)` constant function, shared with the PWM encoder.
- **Sub-module `pwm_edge_sync`:** synchronizer, delay flop, and `rise`/`fall` outputs, parameterized by `SYNC_STAGES`. It is reused by other pin inputs.
- **Top level:** prescaler, counters, FSM and output registers stay in `pwm_capture`.

## Test plan
- **Steady PWM:** PRESCALER = 0, WIDTH = 8; `pwm_in` high 3 / low 5 `clk`, repeated. From the second full period on, each `valid` shows `high_time` = 3, `period` = 8, `timeout` = 0. `valid` arrives once every 8 cycles.
- **Reset while high:** hold `pwm_in` = 1 through reset release, then run 10 high / 22 low. No `valid` until the first full cycle completes. That report shows 10/32, never a partial high time.
- **Stuck high:** `pwm_in` stuck at 1, WIDTH = 4. Within 16 cycles, `valid` fires with `high_time` = 15, `period` = 15, `timeout` = 1. A timeout `valid` repeats every 16 cycles. Resuming 2/6 PWM clears `timeout` at the next normal report.
- **Stuck low:** `pwm_in` stuck at 0, WIDTH = 4. `valid` fires with `high_time` = 0, `period` = 15, `timeout` = 1.
- **Prescaler:** PRESCALER = 2; input high 40 / low 24 `clk`. Reports show `high_time` = 10±1 and `period` = 16±1.
- **Edge at saturation:** WIDTH = 4; `rise` lands exactly on the tick where `cnt` = 15 in LOW. A normal `valid` is produced with saturated `period` = 15, and no spurious timeout strobe follows.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared types and helpers for the PWM capture path
//
// Purpose: capture FSM state encoding and the counter-ceiling helper that the
// PWM encoder uses too, so both ends agree on what "full scale" means.

package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } pwm_cap_state_t;

  // Largest value a width-bit tick counter can hold.
  function automatic int cnt_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - PWM pin in, measurement results out
//
// Purpose: bundles the PWM input with the measurement result bus.
// Signals:
//   pwm_in    - asynchronous PWM pin
//   high_time - ticks high in the last measured cycle
//   period    - ticks rise-to-rise in the last measured cycle
//   valid     - one-cycle strobe when high_time/period update
//   timeout   - level, last measurement ended by saturation
// Modports: slave = capture block, master = whoever drives the pin and reads results.

interface pwm_capture_if #(
  parameter int WIDTH = 8
);

  logic             pwm_in;
  logic [WIDTH-1:0] high_time;
  logic [WIDTH-1:0] period;
  logic             valid;
  logic             timeout;

  modport master (
    output pwm_in,
    input  high_time,
    input  period,
    input  valid,
    input  timeout
  );

  modport slave (
    input  pwm_in,
    output high_time,
    output period,
    output valid,
    output timeout
  );

endinterface

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - pin synchronizer with rise/fall detection
//
// Purpose: brings an asynchronous pin into the clk domain and flags edges.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   i_async   - asynchronous input pin
//   o_level   - synchronized level
//   o_rise    - one cycle high on a 0->1 of o_level
//   o_fall    - one cycle high on a 1->0 of o_level

module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_dly;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time and period measurement
//
// Purpose: measures high time and rise-to-rise period of a PWM pin in
// prescaled ticks; stuck inputs report as 0 % / 100 % through a timeout.
// Ports:
//   clk  - clock, all logic on rising edge
//   rst  - synchronous active-high reset
//   bus  - pwm_capture_if slave: pwm_in in; high_time, period, valid, timeout out
// Parameters: WIDTH (counter/result width), PRESCALER (tick = 2^PRESCALER clk),
//   SYNC_STAGES (input synchronizer depth, >= 2).

module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PRESCALER   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  pwm_capture_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(cnt_max(WIDTH));

  // The synchronizer flops reset to 0, so a low level is not trustworthy
  // until the chain and delay flop have refilled from the pin.
  localparam int FLUSH = SYNC_STAGES + 1;
  localparam int FW    = $clog2(FLUSH + 1);

  logic w_synced;
  logic w_rise;
  logic w_fall;
  logic w_tick;

  pwm_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (bus.pwm_in),
    .o_level (w_synced),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Free-running prescaler, never restarted by input edges.
  if (PRESCALER == 0) begin : g_nopre
    assign w_tick = 1'b1;
  end else begin : g_pre
    logic [PRESCALER-1:0] r_pre;
    always_ff @(posedge clk) begin
      if (rst) r_pre <= '0;
      else     r_pre <= r_pre + 1'b1;
    end
    assign w_tick = &r_pre;
  end

  pwm_cap_state_t   r_state;
  pwm_cap_state_t   w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi_cnt;
  logic [WIDTH-1:0] r_high_time;
  logic [WIDTH-1:0] r_period;
  logic             r_valid;
  logic             r_timeout;
  logic [FW-1:0]    r_flush;
  logic             w_flushed;
  logic             w_edge_exit;
  logic             w_timeout;
  logic             w_report;
  logic [WIDTH:0]   w_sum;

  assign w_flushed = (r_flush == FW'(FLUSH));
  assign w_sum     = {1'b0, r_hi_cnt} + {1'b0, r_cnt};
  assign w_report  = (r_state == LOW) && w_rise;

  always_ff @(posedge clk) begin
    if (rst)             r_flush <= '0;
    else if (!w_flushed) r_flush <= r_flush + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_edge_exit = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_flushed && !w_synced) begin
          w_state_nxt = ARM;
          w_edge_exit = w_fall;
        end
      end
      ARM: begin
        if (w_rise) begin
          w_state_nxt = HIGH;
          w_edge_exit = 1'b1;
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_state_nxt = LOW;
          w_edge_exit = 1'b1;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_state_nxt = HIGH;
          w_edge_exit = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // An edge landing on the saturating tick wins over the timeout.
    w_timeout = w_tick && (r_cnt == MAX) && !w_edge_exit;
    if (w_timeout) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hi_cnt    <= '0;
      r_high_time <= '0;
      r_period    <= '0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= 1'b0;
      if (w_timeout) begin
        r_cnt       <= '0;
        r_high_time <= w_synced ? MAX : '0;
        r_period    <= MAX;
        r_valid     <= 1'b1;
        r_timeout   <= 1'b1;
      end else begin
        // The edge cycle itself counts when it carries a tick.
        if (w_edge_exit)  r_cnt <= w_tick ? WIDTH'(1) : '0;
        else if (w_tick)  r_cnt <= r_cnt + 1'b1;

        if ((r_state == HIGH) && w_fall) r_hi_cnt <= r_cnt;

        if (w_report) begin
          r_high_time <= r_hi_cnt;
          r_period    <= w_sum[WIDTH] ? MAX : w_sum[WIDTH-1:0];
          r_valid     <= 1'b1;
          r_timeout   <= w_sum[WIDTH];
        end
      end
    end
  end

  assign bus.high_time = r_high_time;
  assign bus.period    = r_period;
  assign bus.valid     = r_valid;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture

module tb_pwm_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  logic pwm  = 1'b0;

  pwm_capture_if #(.WIDTH(8)) if0 ();
  pwm_capture_if #(.WIDTH(4)) if1 ();
  pwm_capture_if #(.WIDTH(8)) if2 ();

  assign if0.pwm_in = pwm;
  assign if1.pwm_in = pwm;
  assign if2.pwm_in = pwm;

  pwm_capture #(.WIDTH(8), .PRESCALER(0), .SYNC_STAGES(2)) u0 (.clk(clk), .rst(rst0), .bus(if0));
  pwm_capture #(.WIDTH(4), .PRESCALER(0), .SYNC_STAGES(2)) u1 (.clk(clk), .rst(rst1), .bus(if1));
  pwm_capture #(.WIDTH(8), .PRESCALER(2), .SYNC_STAGES(2)) u2 (.clk(clk), .rst(rst2), .bus(if2));

  typedef struct {
    int hi;
    int per;
    int to;
    int tol;
    int gap;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_cyc[3] = '{-1, -1, -1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int id, input int hi, input int per, input int to,
                      input int tol, input int gap);
    exp_t e;
    e.hi = hi; e.per = per; e.to = to; e.tol = tol; e.gap = gap;
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic score(input int id, input int hi, input int per, input int to);
    exp_t e;
    check($sformatf("u%0d_sb_nonempty", id), int'(qsize(id) > 0), 1);
    if (qsize(id) > 0) begin
      case (id)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("u%0d_high_time", id), hi, clamp(hi, e.hi - e.tol, e.hi + e.tol));
      check($sformatf("u%0d_period", id), per, clamp(per, e.per - e.tol, e.per + e.tol));
      check($sformatf("u%0d_timeout", id), to, e.to);
      if (e.gap != 0) check($sformatf("u%0d_valid_gap", id), cyc - last_cyc[id], e.gap);
    end
    if (last_cyc[id] >= 0)
      check($sformatf("u%0d_not_back_to_back", id), int'(cyc - last_cyc[id] > 1), 1);
    last_cyc[id] = cyc;
  endtask

  always @(negedge clk) begin
    if (!rst0 && if0.valid) score(0, int'(if0.high_time), int'(if0.period), int'(if0.timeout));
    if (!rst1 && if1.valid) score(1, int'(if1.high_time), int'(if1.period), int'(if1.timeout));
    if (!rst2 && if2.valid) score(2, int'(if2.high_time), int'(if2.period), int'(if2.timeout));
  end

  task automatic hold(input logic v, input int n);
    pwm = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic restart(input int id, input logic v);
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    pwm  = v;
    repeat (4) @(negedge clk);
    last_cyc[0] = -1; last_cyc[1] = -1; last_cyc[2] = -1;
    case (id)
      0:       rst0 = 1'b0;
      1:       rst1 = 1'b0;
      default: rst2 = 1'b0;
    endcase
  endtask

  task automatic drain(input int id, input string tag);
    check(tag, qsize(id), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_high_time", int'(if0.high_time), 0);
    check("rst_period",    int'(if0.period),    0);
    check("rst_valid",     int'(if0.valid),     0);
    check("rst_timeout",   int'(if0.timeout),   0);
    check("rst_w4_period", int'(if1.period),    0);

    // Steady 3 high / 5 low.
    restart(0, 1'b0);
    hold(1'b0, 5);
    for (int p = 0; p < 7; p++) begin
      if (p > 0) push(0, 3, 8, 0, 0, (p > 1) ? 8 : 0);
      hold(1'b1, 3);
      hold(1'b0, 5);
    end
    drain(0, "steady_drain");

    // Pin high through reset release: the pulse in progress is discarded.
    restart(0, 1'b1);
    hold(1'b1, 6);
    hold(1'b0, 22);
    hold(1'b1, 10);
    hold(1'b0, 22);
    push(0, 10, 32, 0, 0, 0);
    hold(1'b1, 10);
    hold(1'b0, 3);
    drain(0, "rst_high_drain");

    // Stuck high on a 4-bit counter, then 2/6 PWM resumes.
    restart(1, 1'b1);
    push(1, 15, 15, 1, 0, 0);
    push(1, 15, 15, 1, 0, 16);
    push(1, 15, 15, 1, 0, 16);
    hold(1'b1, 50);
    drain(1, "stuck_high_drain");
    hold(1'b0, 6);
    for (int p = 0; p < 4; p++) begin
      if (p > 0) push(1, 2, 8, 0, 0, 0);
      hold(1'b1, 2);
      hold(1'b0, 6);
    end
    drain(1, "resume_drain");

    // Stuck low.
    restart(1, 1'b0);
    push(1, 0, 15, 1, 0, 0);
    hold(1'b0, 20);
    drain(1, "stuck_low_drain");

    // Rise on the exact saturating tick in LOW, then a normal cycle.
    restart(1, 1'b0);
    hold(1'b0, 5);
    hold(1'b1, 3);
    hold(1'b0, 15);
    push(1, 3, 15, 1, 0, 0);
    hold(1'b1, 3);
    hold(1'b0, 5);
    push(1, 3, 8, 0, 0, 0);
    hold(1'b1, 3);
    hold(1'b0, 3);
    drain(1, "sat_edge_drain");

    // Prescaled: 40/24 clk at 4 clk per tick.
    restart(2, 1'b0);
    hold(1'b0, 8);
    for (int p = 0; p < 4; p++) begin
      if (p > 0) push(2, 10, 16, 0, 1, 0);
      hold(1'b1, 40);
      hold(1'b0, 24);
    end
    drain(2, "prescale_drain");

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
